// File: rtl/mod_148_timer_defs.sv
// Shared definitions for the clause 148 timer bank and its state machines.
// Holds the channel state encoding, default sizing and the default channel map.
package mod_148_timer_defs;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_EXPIRED = 2'd2
  } timer_state_t;

  localparam int DEF_NUM_TIMERS = 5;
  localparam int DEF_CNT_W      = 16;

  // Default channel assignment; durations come from the integrator.
  localparam int CH_BEACON         = 0;
  localparam int CH_BEACON_DET     = 1;
  localparam int CH_INVALID_BEACON = 2;
  localparam int CH_BURST          = 3;
  localparam int CH_TO_TIMER       = 4;

endpackage

// File: rtl/mod_148_timer_channel.sv
// One timer channel: latched duration, down-counter and IDLE/RUNNING/EXPIRED FSM.
// Outputs are registered alongside the state so they change only on clk edges.
module mod_148_timer_channel
  import mod_148_timer_defs::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit PERIODIC = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] duration,
  output logic             done,
  output logic             not_done,
  output logic             expired
);

  timer_state_t     state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] dur_reg;
  logic             done_reg;
  logic             not_done_reg;
  logic             expired_reg;

  // The counter holds the number of further edges to wait minus one, so a
  // start loads D-1 (D edges of RUNNING) and a periodic reload loads D
  // (D counting edges plus the reload edge).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      dur_reg      <= '0;
      done_reg     <= 1'b0;
      not_done_reg <= 1'b0;
      expired_reg  <= 1'b0;
    end else begin
      expired_reg <= 1'b0;
      if (start) begin
        dur_reg <= duration;
        if (duration == '0) begin
          state_reg    <= ST_EXPIRED;
          cnt_reg      <= '0;
          done_reg     <= 1'b1;
          not_done_reg <= 1'b0;
          expired_reg  <= 1'b1;
        end else begin
          state_reg    <= ST_RUNNING;
          cnt_reg      <= duration - 1'b1;
          done_reg     <= 1'b0;
          not_done_reg <= 1'b1;
        end
      end else if (stop) begin
        state_reg    <= ST_IDLE;
        cnt_reg      <= '0;
        done_reg     <= 1'b0;
        not_done_reg <= 1'b0;
      end else if (state_reg == ST_RUNNING) begin
        if (cnt_reg == '0) begin
          expired_reg <= 1'b1;
          if (PERIODIC) begin
            cnt_reg <= dur_reg;
          end else begin
            state_reg    <= ST_EXPIRED;
            done_reg     <= 1'b1;
            not_done_reg <= 1'b0;
          end
        end else begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
    end
  end

  assign done     = done_reg;
  assign not_done = not_done_reg;
  assign expired  = expired_reg;

endmodule

// File: rtl/mod_148_timer_bank.sv
// Bank of independent clause 148 timers; each channel is a separate instance
// and the bank only slices the per-channel buses.
module mod_148_timer_bank
  import mod_148_timer_defs::*;
#(
  parameter int                      NUM_TIMERS    = DEF_NUM_TIMERS,
  parameter int                      CNT_W         = DEF_CNT_W,
  parameter logic [NUM_TIMERS-1:0]   PERIODIC_MASK = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_TIMERS-1:0]       timer_start,
  input  logic [NUM_TIMERS-1:0]       timer_stop,
  input  logic [NUM_TIMERS*CNT_W-1:0] timer_duration,
  output logic [NUM_TIMERS-1:0]       timer_done,
  output logic [NUM_TIMERS-1:0]       timer_not_done,
  output logic [NUM_TIMERS-1:0]       timer_expired
);

  for (genvar gi = 0; gi < NUM_TIMERS; gi++) begin : g_chan
    mod_148_timer_channel #(
      .CNT_W    (CNT_W),
      .PERIODIC (PERIODIC_MASK[gi])
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (timer_start[gi]),
      .stop     (timer_stop[gi]),
      .duration (timer_duration[gi*CNT_W +: CNT_W]),
      .done     (timer_done[gi]),
      .not_done (timer_not_done[gi]),
      .expired  (timer_expired[gi])
    );
  end

endmodule

// File: tb/tb_mod_148_timer_bank.sv
// Self-checking bench for mod_148_timer_bank: directed scenarios plus random
// traffic, checked every cycle against an elapsed-time model of each channel.
module tb_mod_148_timer_bank;

  localparam int N = 5;
  localparam int W = 4;
  localparam logic [N-1:0] PMASK = 5'b10000;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   timer_start;
  logic [N-1:0]   timer_stop;
  logic [N*W-1:0] timer_duration;
  logic [N-1:0]   timer_done;
  logic [N-1:0]   timer_not_done;
  logic [N-1:0]   timer_expired;

  mod_148_timer_bank #(
    .NUM_TIMERS    (N),
    .CNT_W         (W),
    .PERIODIC_MASK (PMASK)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .timer_start    (timer_start),
    .timer_stop     (timer_stop),
    .timer_duration (timer_duration),
    .timer_done     (timer_done),
    .timer_not_done (timer_not_done),
    .timer_expired  (timer_expired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int now    = 0;
  bit act[N];
  int st[N];
  int dl[N];
  logic [N-1:0] pmask = PMASK;

  // Model: a channel is either inactive or active since edge st with duration dl;
  // everything else follows from the elapsed edge count.
  task automatic step();
    @(posedge clk);
    now++;
    for (int i = 0; i < N; i++) begin
      if (!reset_n) act[i] = 1'b0;
      else if (timer_start[i]) begin
        act[i] = 1'b1;
        st[i]  = now;
        dl[i]  = int'(timer_duration[i*W +: W]);
      end else if (timer_stop[i]) act[i] = 1'b0;
    end
    #1;
  endtask

  function automatic logic [N-1:0] exp_done();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int e = now - st[i];
      bit per = pmask[i] && dl[i] > 0;
      r[i] = act[i] && !per && e >= dl[i];
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_not_done();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int e = now - st[i];
      bit per = pmask[i] && dl[i] > 0;
      r[i] = act[i] && (per || e < dl[i]);
    end
    return r;
  endfunction

  function automatic logic [N-1:0] exp_expired();
    logic [N-1:0] r = '0;
    for (int i = 0; i < N; i++) begin
      int e = now - st[i];
      bit per = pmask[i] && dl[i] > 0;
      if (per) r[i] = act[i] && e >= dl[i] && ((e - dl[i]) % (dl[i] + 1)) == 0;
      else     r[i] = act[i] && e == dl[i];
    end
    return r;
  endfunction

  task automatic set_dur(input int ch, input int d);
    timer_duration[ch*W +: W] = W'(d);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    timer_start = '1;
    timer_stop = '1;
    timer_duration = {N{4'd3}};
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if ({timer_done, timer_not_done, timer_expired} !== '0) begin
        errors++;
        $display("FAIL reset c=%0d: got done=%b not_done=%b expired=%b required all 0",
                 c, timer_done, timer_not_done, timer_expired);
      end
    end
    timer_start = '0;
    timer_stop = '0;
    reset_n = 1'b1;
    step();
    checks++;
    if ({timer_done, timer_not_done, timer_expired} !== '0) begin
      errors++;
      $display("FAIL reset_release: got done=%b not_done=%b expired=%b required all 0",
               timer_done, timer_not_done, timer_expired);
    end
  endtask

  task automatic test_oneshot();
    set_dur(0, 4);
    for (int c = 0; c < 10; c++) begin
      timer_start = (c == 0) ? 5'b00001 : 5'b00000;
      timer_stop  = (c == 8) ? 5'b00001 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL oneshot_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL oneshot_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL oneshot_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
      if (c == 4) begin
        checks++;
        if ({timer_done[0], timer_not_done[0], timer_expired[0]} !== 3'b101) begin errors++;
          $display("FAIL oneshot_expiry_cycle: got d/nd/x=%b%b%b required 101",
                   timer_done[0], timer_not_done[0], timer_expired[0]); end
      end
    end
  endtask

  task automatic test_zero_restart();
    set_dur(1, 0);
    set_dur(2, 10);
    for (int c = 0; c < 21; c++) begin
      timer_start = (c == 0) ? 5'b00110 : (c == 6) ? 5'b00100 : 5'b00000;
      timer_stop  = (c == 19) ? 5'b00110 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL zero_restart_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL zero_restart_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL zero_restart_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
      if (c == 10 || c == 16) begin
        checks++;
        if (timer_expired[2] !== (c == 16)) begin errors++;
          $display("FAIL restart_pulse c=%0d: got %b required %b", c, timer_expired[2], c == 16); end
      end
    end
  endtask

  task automatic test_start_stop();
    set_dur(3, 3);
    for (int c = 0; c < 10; c++) begin
      timer_start = (c == 0 || c == 6) ? 5'b01000 : 5'b00000;
      timer_stop  = (c == 0 || c == 8) ? 5'b01000 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL start_stop_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL start_stop_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL start_stop_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
    end
  endtask

  task automatic test_periodic();
    set_dur(4, 5);
    for (int c = 0; c < 34; c++) begin
      timer_start = (c == 0) ? 5'b10000 : 5'b00000;
      timer_stop  = (c == 32) ? 5'b10000 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL periodic_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL periodic_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL periodic_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
      if (c >= 5 && c < 32) begin
        checks++;
        if (timer_expired[4] !== ((c - 5) % 6 == 0)) begin errors++;
          $display("FAIL periodic_pulse c=%0d: got %b required %b", c, timer_expired[4], (c - 5) % 6 == 0); end
      end
    end
  endtask

  task automatic test_reset_midrun();
    set_dur(0, 8);
    for (int c = 0; c < 16; c++) begin
      timer_start = (c == 0) ? 5'b00001 : 5'b00000;
      timer_stop  = '0;
      reset_n     = (c == 3) ? 1'b0 : 1'b1;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL reset_mid_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL reset_mid_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL reset_mid_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_no_wrap();
    for (int c = 0; c < 19; c++) begin
      if (c == 0) set_dur(0, 15);
      if (c == 3) set_dur(0, 2);
      timer_start = (c == 0) ? 5'b00001 : 5'b00000;
      timer_stop  = (c == 18) ? 5'b00001 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL no_wrap_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL no_wrap_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL no_wrap_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
      if (c == 14 || c == 15) begin
        checks++;
        if (timer_done[0] !== (c == 15)) begin errors++;
          $display("FAIL no_wrap_expiry c=%0d: got done=%b required %b", c, timer_done[0], c == 15); end
      end
    end
  endtask

  task automatic test_held_start();
    set_dur(1, 2);
    for (int c = 0; c < 14; c++) begin
      timer_start = (c < 10) ? 5'b00010 : 5'b00000;
      timer_stop  = (c == 13) ? 5'b00010 : 5'b00000;
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL held_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL held_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL held_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        timer_start[i] = ($urandom_range(0, 9) == 0);
        timer_stop[i]  = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 3) == 0)
          set_dur(i, ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 6)));
      end
      reset_n = ($urandom_range(0, 59) != 0);
      step();
      checks += 3;
      if (timer_done !== exp_done()) begin errors++;
        $display("FAIL random_done c=%0d: got %b required %b", c, timer_done, exp_done()); end
      if (timer_not_done !== exp_not_done()) begin errors++;
        $display("FAIL random_not_done c=%0d: got %b required %b", c, timer_not_done, exp_not_done()); end
      if (timer_expired !== exp_expired()) begin errors++;
        $display("FAIL random_expired c=%0d: got %b required %b", c, timer_expired, exp_expired()); end
    end
    reset_n = 1'b1;
    timer_start = '0;
    timer_stop = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      st[i]  = 0;
      dl[i]  = 0;
    end
    reset_n = 1'b0;
    timer_start = '0;
    timer_stop = '0;
    timer_duration = '0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_zero_restart();
    test_start_stop();
    test_periodic();
    test_reset_midrun();
    test_no_wrap();
    test_held_start();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mod_148_timer_bank.md
MOD_148_TIMER_BANK -- requirements
Module: mod_148_timer_bank

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 5, number of independent timer channels (1..32).
REQ-002 SHALL have parameter CNT_W, default 16, duration/counter width in clock cycles.
REQ-003 SHALL have parameter PERIODIC_MASK, default 0 (NUM_TIMERS bits), bit i=1 makes channel i auto-reloading.
REQ-004 SHALL have port clk, input, 1, single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port timer_start, input, NUM_TIMERS, per-channel start/restart request, level sampled each clk.
REQ-007 SHALL have port timer_stop, input, NUM_TIMERS, per-channel abort request.
REQ-008 SHALL have port timer_duration, input, NUM_TIMERS*CNT_W, channel i duration at bits [i*CNT_W +: CNT_W], in clk cycles.
REQ-009 SHALL have port timer_done, output, NUM_TIMERS, channel expired (IEEE 802.3 xxx_timer_done).
REQ-010 SHALL have port timer_not_done, output, NUM_TIMERS, channel running (IEEE 802.3 xxx_timer_not_done).
REQ-011 SHALL have port timer_expired, output, NUM_TIMERS, one-cycle pulse on every expiry event.

Function
REQ-012 Each channel SHALL implement states IDLE, RUNNING, EXPIRED; outputs are registered and decoded from state: IDLE done=0/not_done=0, RUNNING 0/1, EXPIRED 1/0.
REQ-013 Channel SHALL latch timer_duration D into its counter at the edge sampling timer_start=1; later duration changes SHALL be ignored until the next start.
REQ-014 For D>=1, not_done SHALL be 1 for exactly D cycles after the start edge; done and the expired pulse SHALL assert on cycle D+1.
REQ-015 For D=0, channel SHALL go directly to EXPIRED; done and expired pulse assert the cycle after the start edge, not_done never asserts.
REQ-016 Start while RUNNING or EXPIRED SHALL restart: counter reloaded, state RUNNING, no expired pulse for the aborted run.
REQ-017 Stop SHALL force IDLE on the next edge from any state, clearing done and not_done.
REQ-018 Simultaneous start and stop on a channel SHALL be treated as start (start wins).
REQ-019 Start asserted on the expiry cycle SHALL win over expiry: no expired pulse, run restarts.
REQ-020 One-shot channel SHALL hold EXPIRED (done=1) until start or stop.
REQ-021 Periodic channel with D>=1 SHALL reload the latched D on expiry, remain RUNNING (not_done=1, done=0), and pulse timer_expired once per D+1 cycles... period exactly D cycles of counting plus the reload cycle.
REQ-022 Periodic channel with D=0 SHALL behave as one-shot.
REQ-023 Timer_start held high continuously SHALL restart every cycle (timer never expires for D>=1).
REQ-024 Counter SHALL never wrap: decrement stops at terminal count; max D = 2^CNT_W-1.
REQ-025 Channels SHALL be fully independent; no shared state other than clk/reset_n.

Reset
REQ-026 reset_n=0 at a clk edge SHALL force every channel to IDLE, counter 0, timer_done=0, timer_not_done=0, timer_expired=0, overriding start/stop.
REQ-027 Reset asserted mid-run SHALL discard the run; the first start after reset_n=1 behaves as from power-up.

Structure
REQ-028 State encodings and default NUM_TIMERS/CNT_W SHALL live in shared package/include mod_148_timer_defs, reused by the clause 148 state-machine modules.
REQ-029 SHALL instantiate NUM_TIMERS copies of sub-module mod_148_timer_channel (one counter + 3-state FSM) via generate; the bank adds only bus slicing.
REQ-030 Default channel map SHALL be 0 beacon, 1 beacon_det, 2 invalid_beacon, 3 burst, 4 to_timer, durations supplied by the integrator from clk period.

Verification
REQ-031 Ch0 D=4, start 1 cycle -> not_done=1 cycles 1..4, done=1 and expired pulse cycle 5, done held until stop.
REQ-032 Ch1 D=0, start -> done=1 next cycle, not_done never 1; ch2 D=10 restarted at cycle 6 -> done at cycle 17, no pulse at 11.
REQ-033 Ch3 start+stop same cycle, D=3 -> runs, done at cycle 4; stop at cycle 2 of run -> both outputs 0 next cycle.
REQ-034 PERIODIC_MASK bit4=1, D=5 -> expired pulses every 6 cycles, not_done stays 1, done stays 0 for 5 periods.
REQ-035 Reset_n low at cycle 3 of ch0 D=8 run -> all outputs 0 next edge; no expiry afterwards without new start.
REQ-036 CNT_W=4, D=15, duration bus changed to 2 mid-run -> expiry still at cycle 16, counter never wraps.
